// File: rtl/div_pkg.sv
// Shared types and defaults for the iterative restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

    localparam int unsigned DIV_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/borrow_sub.sv
// Ripple-borrow subtractor built from per-bit full subtractors: {bout, diff} = a - b - bin.
module borrow_sub #(
    parameter int unsigned WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    logic [WIDTH:0] br;

    assign br[0] = bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign diff[i]  = a[i] ^ b[i] ^ br[i];
        assign br[i+1]  = (~a[i] & b[i]) | (~a[i] & br[i]) | (b[i] & br[i]);
    end

    assign bout = br[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider producing one quotient bit per clock, with a
// start/busy/done handshake. Divide-by-zero completes in a single cycle.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic             borrow;

    assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    borrow_sub #(
        .WIDTH(WIDTH + 1)
    ) u_sub (
        .a    (r_shift),
        .b    ({1'b0, divisor_q}),
        .bin  (1'b0),
        .diff (diff),
        .bout (borrow)
    );

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        state_d   = RUN;
                        divisor_d = divisor;
                        q_d       = dividend;
                        r_d       = '0;
                        cnt_d     = '0;
                        dbz_d     = 1'b0;
                    end else begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end
                end
            end
            RUN: begin
                // Restore by keeping the shifted value when the trial subtraction borrows.
                q_d   = {q_q[WIDTH-2:0], ~borrow};
                r_d   = borrow ? r_shift : diff;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastStep) begin
                    state_d     = DONE;
                    quotient_d  = q_d;
                    remainder_d = r_d[WIDTH-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            q_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector and random bench for seq_divider (WIDTH=8).
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    seq_divider #(
        .WIDTH(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulse start for one cycle, then follow the operation to done and one cycle beyond.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic ez,
                          input int elat);
        int lat;
        int busy_bad;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        lat      = 1;
        busy_bad = 0;
        while (!done && lat < 40) begin
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, elat);
        check({tag, " busy while running"}, busy_bad, 0);
        check({tag, " busy with done"}, {31'd0, busy}, 0);
        check({tag, " quotient"}, {24'd0, quotient}, {24'd0, eq});
        check({tag, " remainder"}, {24'd0, remainder}, {24'd0, er});
        check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, ez});
        @(negedge clk);
        check({tag, " done width"}, {31'd0, done}, 0);
    endtask

    initial begin
        logic [7:0] opa[40];
        logic [7:0] opb[40];
        int pulses;

        tbl[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 9};
        tbl[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 9};
        tbl[2]  = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 9};
        tbl[3]  = '{8'd3,   8'd200, 8'd0,   8'd3,  1'b0, 9};
        tbl[4]  = '{8'd5,   8'd0,   8'hFF,  8'd5,  1'b1, 1};
        tbl[5]  = '{8'd9,   8'd3,   8'd3,   8'd0,  1'b0, 9};
        tbl[6]  = '{8'd200, 8'd9,   8'd22,  8'd2,  1'b0, 9};
        tbl[7]  = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 9};
        tbl[8]  = '{8'd17,  8'd17,  8'd1,   8'd0,  1'b0, 9};
        tbl[9]  = '{8'd250, 8'd16,  8'd15,  8'd10, 1'b0, 9};
        tbl[10] = '{8'd128, 8'd3,   8'd42,  8'd2,  1'b0, 9};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 0);
        check("reset done", {31'd0, done}, 0);
        check("reset quotient", {24'd0, quotient}, 0);
        check("reset remainder", {24'd0, remainder}, 0);
        check("reset div_by_zero", {31'd0, div_by_zero}, 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
                   tbl[i].z, tbl[i].lat);
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d hold quotient", i), {24'd0, quotient}, {24'd0, tbl[i].q});
            check($sformatf("vec%0d hold remainder", i), {24'd0, remainder}, {24'd0, tbl[i].r});
            check($sformatf("vec%0d hold dbz", i), {31'd0, div_by_zero}, {31'd0, tbl[i].z});
        end

        // Reset in the middle of a division aborts it and clears the results.
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd9;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", {31'd0, busy}, 0);
        check("abort done", {31'd0, done}, 0);
        check("abort quotient", {24'd0, quotient}, 0);
        check("abort remainder", {24'd0, remainder}, 0);
        check("abort div_by_zero", {31'd0, div_by_zero}, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || busy === 1'b1) pulses++;
            @(negedge clk);
        end
        check("abort no activity", pulses, 0);
        run_op("after abort", 8'd200, 8'd9, 8'd22, 8'd2, 1'b0, 9);

        // start held high: accepts at edges 0, 10, 20, 30; done after edges 8, 18, 28, 38.
        for (int k = 0; k < 40; k++) begin
            opa[k]   = 8'($urandom);
            opb[k]   = 8'($urandom_range(1, 255));
            dividend = opa[k];
            divisor  = opb[k];
            start    = 1'b1;
            @(negedge clk);
            check($sformatf("held k%0d done", k), {31'd0, done}, {31'd0, (k % 10) == 8});
            if ((k % 10) == 8) begin
                check($sformatf("held k%0d quotient", k), {24'd0, quotient},
                      {24'd0, opa[k-8] / opb[k-8]});
                check($sformatf("held k%0d remainder", k), {24'd0, remainder},
                      {24'd0, opa[k-8] % opb[k-8]});
            end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if (b == 8'd0)
                run_op($sformatf("rnd%0d %0d/0", i, a), a, b, 8'hFF, a, 1'b1, 1);
            else
                run_op($sformatf("rnd%0d %0d/%0d", i, a, b), a, b, a / b, a % b, 1'b0, 9);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
